// File: rtl/bu2020_io_pkg.sv
// bu2020_io_pkg: shared constants for the BU2020 memory-mapped I/O port.
//   - register offsets inside the four-word window (address_bus[2:1])
//   - STATUS bit positions and CTRL.EN position
//   - default window base and FIFO depth
package bu2020_io_pkg;

  localparam logic [11:0] BU_IO_BASE_DEFAULT  = 12'hFF0;
  localparam int unsigned BU_IO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_off_e;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_TX_OVF     = 4;
  localparam int unsigned ST_RX_UDF     = 5;
  localparam int unsigned ST_TX_CNT_LSB = 8;
  localparam int unsigned ST_RX_CNT_LSB = 12;

  localparam int unsigned CTRL_EN = 0;

endpackage

// File: rtl/bu_io_fifo.sv
// bu_io_fifo: synchronous FIFO with extra-MSB pointers.
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   i_push, i_wdata   write request/data; ignored when full (pre-edge)
//   i_pop             read request; ignored when empty (pre-edge)
//   o_rdata           current head entry
//   o_full, o_empty   occupancy flags
//   o_count           wptr - rptr
module bu_io_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bu_io_port.sv
// bu_io_port: BU2020 bus responder for a four-word I/O window at BASE.
// Offsets: 0 TXDATA (W push / R 0), 1 RXDATA (R pop), 2 STATUS, 3 CTRL.
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   address_bus[11:0]     CPU byte address (bit 0 ignored)
//   data_bus[15:0]        bidirectional; driven one cycle after a read hit
//   write_mode            1 = write, 0 = read
//   tx_data/tx_valid/tx_ready   outbound stream (TX FIFO head)
//   rx_data/rx_valid/rx_ready   inbound stream (RX FIFO)
// Build option: BU_IO_RX_EN enables the RX FIFO; without it RXDATA
// always underflows and rx_ready is 0.
module bu_io_port
  import bu2020_io_pkg::*;
#(
  parameter logic [11:0] BASE  = BU_IO_BASE_DEFAULT,
  parameter int unsigned DEPTH = BU_IO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] address_bus,
  inout  wire  [15:0] data_bus,
  input  logic        write_mode,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic        r_en;
  logic        r_tx_ovf;
  logic        r_rx_udf;
  logic        r_rd_en;
  logic [15:0] r_rd_data;

  logic        w_hit;
  reg_off_e    w_off;
  logic        w_bus_wr;
  logic        w_bus_rd;
  logic        w_st_wr;
  logic        w_rx_rd;
  logic [15:0] w_status;
  logic [15:0] w_rd_mux;

  logic          w_tx_push;
  logic          w_tx_pop;
  logic [15:0]   w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [AW:0]   w_tx_count;

  logic          w_rx_full;
  logic          w_rx_empty;
  logic [15:0]   w_rx_head;
  logic [3:0]    w_rx_cnt4;
  logic          w_unused_addr0;

  assign w_unused_addr0 = address_bus[0];

  assign w_hit    = (address_bus[11:3] == BASE[11:3]);
  assign w_off    = reg_off_e'(address_bus[2:1]);
  assign w_bus_wr = w_hit && write_mode;
  assign w_bus_rd = w_hit && !write_mode;
  assign w_st_wr  = w_bus_wr && (w_off == REG_STATUS);
  assign w_rx_rd  = w_bus_rd && (w_off == REG_RXDATA);

  // TX path: bus writes queue regardless of EN; EN gates only the handshake.
  assign w_tx_push = w_bus_wr && (w_off == REG_TXDATA);
  assign w_tx_pop  = tx_valid && tx_ready;
  assign tx_valid  = !w_tx_empty && r_en;
  assign tx_data   = w_tx_head;

  bu_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_wdata (data_bus),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

`ifdef BU_IO_RX_EN
  logic        w_rx_push;
  logic        w_rx_pop;
  logic [AW:0] w_rx_count;

  assign rx_ready  = !w_rx_full && r_en;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = w_rx_rd && !w_rx_empty;
  assign w_rx_cnt4 = 4'(w_rx_count);

  bu_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );
`else
  logic w_unused_rx;

  assign w_unused_rx = ^{rx_data, rx_valid};
  assign rx_ready    = 1'b0;
  assign w_rx_full   = 1'b0;
  assign w_rx_empty  = 1'b1;
  assign w_rx_head   = '0;
  assign w_rx_cnt4   = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL]           = w_tx_full;
    w_status[ST_TX_EMPTY]          = w_tx_empty;
    w_status[ST_RX_EMPTY]          = w_rx_empty;
    w_status[ST_RX_FULL]           = w_rx_full;
    w_status[ST_TX_OVF]            = r_tx_ovf;
    w_status[ST_RX_UDF]            = r_rx_udf;
    w_status[ST_TX_CNT_LSB +: 4]   = 4'(w_tx_count);
    w_status[ST_RX_CNT_LSB +: 4]   = w_rx_cnt4;
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      REG_TXDATA: w_rd_mux = '0;
      REG_RXDATA: w_rd_mux = w_rx_empty ? 16'h0000 : w_rx_head;
      REG_STATUS: w_rd_mux = w_status;
      REG_CTRL:   w_rd_mux = {15'd0, r_en};
      default:    w_rd_mux = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_udf  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_en <= w_bus_rd;
      if (w_bus_rd) begin
        r_rd_data <= w_rd_mux;
      end
      if (w_bus_wr && (w_off == REG_CTRL)) begin
        r_en <= data_bus[CTRL_EN];
      end
      r_tx_ovf <= (w_tx_push && w_tx_full) ||
                  (r_tx_ovf && !(w_st_wr && data_bus[ST_TX_OVF]));
      r_rx_udf <= (w_rx_rd && w_rx_empty) ||
                  (r_rx_udf && !(w_st_wr && data_bus[ST_RX_UDF]));
    end
  end

  assign data_bus = r_rd_en ? r_rd_data : 'z;

endmodule

// File: tb/tb_bu_io_port.sv
// tb_bu_io_port: directed bench for bu_io_port (BASE=FF0, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled there too.
// A released bus is detected by driving 16'h0000 from the bench and
// expecting to read exactly that back.
module tb_bu_io_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] address_bus;
  logic        write_mode;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  wire  [15:0] data_bus;

  logic        r_tb_oe;
  logic [15:0] r_tb_dout;
  logic [15:0] d;
  logic [15:0] d2;

  int errors = 0;
  int checks = 0;

  assign data_bus = r_tb_oe ? r_tb_dout : 'z;

  always #5 clk = ~clk;

  bu_io_port #(
    .BASE  (12'hFF0),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .write_mode  (write_mode),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_z(input string tag);
    r_tb_oe   = 1'b1;
    r_tb_dout = 16'h0000;
    #1;
    chk(tag, data_bus, 16'h0000);
    r_tb_oe   = 1'b0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] v);
    address_bus = a;
    write_mode  = 1'b1;
    r_tb_oe     = 1'b1;
    r_tb_dout   = v;
    @(negedge clk);
    write_mode  = 1'b0;
    r_tb_oe     = 1'b0;
    address_bus = 12'h000;
  endtask

  // Returns the response word, then lets the release edge pass.
  task automatic bus_read(input logic [11:0] a, output logic [15:0] v);
    address_bus = a;
    write_mode  = 1'b0;
    r_tb_oe     = 1'b0;
    @(negedge clk);
    address_bus = 12'h000;
    v = data_bus;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    address_bus = 12'h000;
    write_mode  = 1'b0;
    tx_ready    = 1'b0;
    rx_data     = 16'h0000;
    rx_valid    = 1'b0;
    r_tb_oe     = 1'b0;
    r_tb_dout   = 16'h0000;

    // Reset
    @(negedge clk);
    chk_z("rst_z");
    @(negedge clk);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'h0000);
    chk("rst_tx_data", tx_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // STATUS after reset, Z before and after the response cycle
    chk_z("pre_rd_z");
    bus_read(12'hFF4, d);
    chk("status_reset", d, 16'h0006);
    chk_z("post_rd_z");

    // Address just below the window must not be answered
    address_bus = 12'hFE8;
    @(negedge clk);
    address_bus = 12'h000;
    chk_z("miss_z");
    @(negedge clk);

    bus_read(12'hFF0, d);
    chk("txdata_rd", d, 16'h0000);

    // CTRL, with address bit 0 set on the readback
    bus_write(12'hFF6, 16'h0001);
    bus_read(12'hFF7, d);
    chk("ctrl_rd", d, 16'h0001);

    // Two queued words, then drained with tx_ready
    bus_write(12'hFF0, 16'hAAAA);
    bus_write(12'hFF0, 16'hBBBB);
    chk("tx_valid_2", {15'd0, tx_valid}, 16'h0001);
    chk("tx_head_a", tx_data, 16'hAAAA);
    bus_read(12'hFF4, d);
    chk("status_cnt2", d, 16'h0204);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_head_b", tx_data, 16'hBBBB);
    chk("tx_valid_1", {15'd0, tx_valid}, 16'h0001);
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_drained", {15'd0, tx_valid}, 16'h0000);

    // Overflow: fifth word dropped
    for (int i = 1; i <= 5; i++) begin
      bus_write(12'hFF0, 16'(i));
    end
    bus_read(12'hFF4, d);
    chk("status_ovf", d, 16'h0415);
    chk("tx_head_1", tx_data, 16'h0001);
    bus_write(12'hFF4, 16'h0010);
    bus_read(12'hFF4, d);
    chk("status_ovf_clr", d, 16'h0405);

    // Push to a full FIFO in the same cycle as an external pop
    tx_ready = 1'b1;
    bus_write(12'hFF0, 16'h9999);
    tx_ready = 1'b0;
    chk("tx_head_2", tx_data, 16'h0002);
    bus_read(12'hFF4, d);
    chk("status_simul", d, 16'h0314);
    bus_write(12'hFF4, 16'h0010);

    // EN=0 blocks the external handshakes
    bus_write(12'hFF6, 16'h0000);
    chk("en0_tx_valid", {15'd0, tx_valid}, 16'h0000);
    chk("en0_rx_ready", {15'd0, rx_ready}, 16'h0000);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("en0_no_pop", tx_data, 16'h0002);
    bus_write(12'hFF6, 16'h0001);

    // RX path
`ifdef BU_IO_RX_EN
    chk("rx_ready_en", {15'd0, rx_ready}, 16'h0001);
`else
    chk("rx_ready_en", {15'd0, rx_ready}, 16'h0000);
`endif
    rx_data  = 16'h1234;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
    bus_read(12'hFF4, d);
`ifdef BU_IO_RX_EN
    chk("status_rx1", d, 16'h1300);
`else
    chk("status_rx1", d, 16'h0304);
`endif
    // Back-to-back RXDATA reads
    address_bus = 12'hFF2;
    write_mode  = 1'b0;
    @(negedge clk);
    d = data_bus;
    @(negedge clk);
    address_bus = 12'h000;
    d2 = data_bus;
    @(negedge clk);
`ifdef BU_IO_RX_EN
    chk("rx_rd1", d, 16'h1234);
`else
    chk("rx_rd1", d, 16'h0000);
`endif
    chk("rx_rd2", d2, 16'h0000);
    bus_read(12'hFF4, d);
    chk("status_udf", d, 16'h0324);
    bus_write(12'hFF4, 16'h0020);
    bus_read(12'hFF4, d);
    chk("status_udf_clr", d, 16'h0304);

    // Reset while TX holds 3 words and a response is on the bus
    chk("pre_rst_tx_valid", {15'd0, tx_valid}, 16'h0001);
    address_bus = 12'hFF4;
    @(negedge clk);
    address_bus = 12'h000;
    chk("pending_rd", data_bus, 16'h0304);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_z("rst_mid_z");
    chk("rst_mid_tx_valid", {15'd0, tx_valid}, 16'h0000);
    chk("rst_mid_tx_data", tx_data, 16'h0000);
    bus_read(12'hFF4, d);
    chk("rst_mid_status", d, 16'h0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
